// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the button conditioner: channel FSM state encoding and counter sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package btn_conditioner_pkg;

    // Per-channel debounce FSM states; the encoding is fixed so that state dumps read the same everywhere.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESS_CHK = 2'd1,
        ST_HELD      = 2'd2,
        ST_REL_CHK   = 2'd3
    } btn_state_e;

    // One counter width covers all three timing parameters, so the debounce and repeat counters share it.
    function automatic int cnt_width(input int unsigned a, input int unsigned b, input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Bundle between the board-side button pins and the conditioned outputs consumed by Top.
// Latency: n/a (wiring only).
// Backpressure: none; the pulses are fire-and-forget and must be sampled by the consumer on the cycle they appear.
interface btn_conditioner_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_raw;
    logic             repeat_en;
    logic [N_BTN-1:0] btn_pulse;
    logic [N_BTN-1:0] btn_level;

    // Board or stimulus side: drives the raw buttons and the repeat enable.
    modport master (
        output btn_raw,
        output repeat_en,
        input  btn_pulse,
        input  btn_level
    );

    // Conditioner side.
    modport slave (
        input  btn_raw,
        input  repeat_en,
        output btn_pulse,
        output btn_level
    );
endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM, and hold-to-repeat pulse generator.
// Latency: press/release accepted DEBOUNCE_CYCLES+2 edges after the first edge that samples the new level.
// Backpressure: none; btn_pulse is a single-cycle strobe.
module btn_debounce_ch
    import btn_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter int          CNT_W           = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic btn_pulse,
    output logic btn_level
);

    // Terminal counts: each counter is compared against value-1 and cleared, so it never needs to hold the full value.
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             in_period_q, in_period_d;   // first repeat already fired; later ones use REPEAT_PERIOD
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;

    // Next-state logic: synchronizer shift, debounce FSM, and repeat counter.
    always_comb begin
        sync1_d     = btn_raw;
        sync2_d     = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        rcnt_d      = rcnt_q;
        in_period_d = in_period_q;
        level_d     = level_q;
        pulse_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                level_d = 1'b0;
                if (sync2_q) begin
                    state_d = ST_PRESS_CHK;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_PRESS_CHK: begin
                if (!sync2_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d     = ST_HELD;
                    level_d     = 1'b1;
                    pulse_d     = 1'b1;
                    rcnt_d      = CNT_ZERO;
                    in_period_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!sync2_q) begin
                    state_d = ST_REL_CHK;
                    cnt_d   = CNT_ZERO;
                end else if (!repeat_en) begin
                    // Dropping the enable cancels the train; re-enabling starts again from the long delay.
                    rcnt_d      = CNT_ZERO;
                    in_period_d = 1'b0;
                end else if (rcnt_q == (in_period_q ? RP_LAST : RD_LAST)) begin
                    pulse_d     = 1'b1;
                    rcnt_d      = CNT_ZERO;
                    in_period_d = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + CNT_ONE;
                end
            end
            ST_REL_CHK: begin
                if (sync2_q) begin
                    // Release bounce: back to HELD silently, repeat timing starts over.
                    state_d     = ST_HELD;
                    rcnt_d      = CNT_ZERO;
                    in_period_d = 1'b0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_IDLE;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                level_d = 1'b0;
            end
        endcase
    end

    // State registers; reset clears everything at once, dropping any pending pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rcnt_q      <= '0;
            in_period_q <= 1'b0;
            level_q     <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rcnt_q      <= rcnt_d;
            in_period_q <= in_period_d;
            level_q     <= level_d;
            pulse_q     <= pulse_d;
        end
    end

    assign btn_pulse = pulse_q;
    assign btn_level = level_q;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions N_BTN raw asynchronous push-buttons into debounced levels and single-cycle press/repeat pulses.
// Latency: DEBOUNCE_CYCLES+2 edges from first sampled press to pulse/level; repeat pulses follow while held.
// Backpressure: none; channels are independent and may pulse in the same cycle.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic               clk,
    input  logic               rst,
    btn_conditioner_if.slave   bus
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

    // One self-contained channel per button; repeat_en is shared by all of them.
    for (genvar i = 0; i < int'(N_BTN); i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .btn_raw   (bus.btn_raw[i]),
            .repeat_en (bus.repeat_en),
            .btn_pulse (bus.btn_pulse[i]),
            .btn_level (bus.btn_level[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed button scenarios against a run-length model of debounce and repeat.
// Latency: inputs change just after the falling edge, outputs are checked on the falling edge.
// Backpressure: n/a.
module tb_btn_conditioner;

    localparam int NB = 4;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    bit   clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    btn_conditioner_if #(.N_BTN(NB)) bus ();

    btn_conditioner #(
        .N_BTN           (NB),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Model: the level flips once the synchronized input has disagreed with it for D+1 consecutive
    // samples; a press flip pulses. While steadily held with repeat enabled, the age of the hold
    // produces pulses at RD, RD+RP, RD+2RP, ...
    bit   m_s1[NB], m_s2[NB], m_lvl[NB];
    int   m_run[NB], m_age[NB];
    logic [NB-1:0] exp_pulse, exp_level;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NB; c++) begin
                m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_run[c] = 0; m_age[c] = 0;
            end
            exp_pulse = '0;
            exp_level = '0;
        end else begin
            for (int c = 0; c < NB; c++) begin
                bit held;
                bit p;
                held = m_lvl[c] && (m_run[c] == 0);
                p    = 0;
                if (m_s2[c] != m_lvl[c]) begin
                    m_run[c]++;
                    m_age[c] = 0;
                    if (m_run[c] == D + 1) begin
                        m_lvl[c] = m_s2[c];
                        m_run[c] = 0;
                        p        = m_s2[c];
                    end
                end else begin
                    m_run[c] = 0;
                    if (held && bus.repeat_en) begin
                        m_age[c]++;
                        if (m_age[c] == RD || (m_age[c] > RD && (m_age[c] - RD) % RP == 0)) p = 1;
                    end else begin
                        m_age[c] = 0;
                    end
                end
                exp_pulse[c] = p;
                exp_level[c] = m_lvl[c];
                m_s2[c] = m_s1[c];
                m_s1[c] = bus.btn_raw[c];
            end
        end
    end

    // Per-cycle comparison plus pulse bookkeeping for the directed checks.
    int pcnt[NB];
    int last_p[NB];
    bit lvl_seen[NB];
    bit lvl_dropped[NB];
    bit prev_lvl[NB];
    bit logq = 0;
    int plog[$];

    initial for (int c = 0; c < NB; c++) begin
        pcnt[c] = 0; last_p[c] = -1; lvl_seen[c] = 0; lvl_dropped[c] = 0; prev_lvl[c] = 0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("cycle_pulse", 32'(bus.btn_pulse), 32'(exp_pulse));
            check("cycle_level", 32'(bus.btn_level), 32'(exp_level));
            for (int c = 0; c < NB; c++) begin
                if (bus.btn_pulse[c]) begin
                    pcnt[c]++;
                    last_p[c] = cyc;
                    if (c == 0 && logq) plog.push_back(cyc);
                end
                if (bus.btn_level[c]) lvl_seen[c] = 1;
                if (prev_lvl[c] && !bus.btn_level[c]) lvl_dropped[c] = 1;
                prev_lvl[c] = bus.btn_level[c];
            end
        end
    end

    // Wait until the given posedge count has been reached, then step just past the falling edge.
    task automatic at_edge(input int n);
        while (cyc < n) @(negedge clk);
        #1;
    endtask

    function automatic int plog_at(input int i);
        return (i < plog.size()) ? plog[i] : -1;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int e, r, a, p0, p1, p2, p3;

    initial begin
        rst           = 1'b1;
        bus.btn_raw   = '0;
        bus.repeat_en = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_pulse", 32'(bus.btn_pulse), 32'h0);
        check("reset_level", 32'(bus.btn_level), 32'h0);
        rst = 1'b0;
        at_edge(cyc + 3);

        // Clean press and release on channel 0.
        p0 = pcnt[0];
        bus.btn_raw[0] = 1'b1; e = cyc + 1;
        at_edge(e + 5);
        check("clean_pulse_early", 32'(bus.btn_pulse[0]), 32'h0);
        check("clean_level_early", 32'(bus.btn_level[0]), 32'h0);
        at_edge(e + 6);
        check("clean_pulse", 32'(bus.btn_pulse[0]), 32'h1);
        check("clean_level", 32'(bus.btn_level[0]), 32'h1);
        at_edge(e + 7);
        check("clean_pulse_width", 32'(bus.btn_pulse[0]), 32'h0);
        at_edge(e + 19);
        bus.btn_raw[0] = 1'b0; r = cyc + 1;
        at_edge(r + 5);
        check("release_level_early", 32'(bus.btn_level[0]), 32'h1);
        at_edge(r + 6);
        check("release_level", 32'(bus.btn_level[0]), 32'h0);
        check("clean_pulse_count", 32'(pcnt[0] - p0), 32'd1);

        // Press bounce on channel 1.
        p1 = pcnt[1];
        for (int k = 0; k < 5; k++) begin
            bus.btn_raw[1] = (k % 2 == 0);
            if (k == 4) e = cyc + 1;
            at_edge(cyc + 2);
        end
        at_edge(e + 12);
        check("bounce_pulse_count", 32'(pcnt[1] - p1), 32'd1);
        check("bounce_pulse_cycle", 32'(last_p[1]), 32'(e + 6));
        bus.btn_raw[1] = 1'b0;
        at_edge(cyc + 10);

        // Short glitch on channel 2.
        p2 = pcnt[2]; lvl_seen[2] = 0;
        bus.btn_raw[2] = 1'b1;
        at_edge(cyc + 3);
        bus.btn_raw[2] = 1'b0;
        at_edge(cyc + 12);
        check("glitch_pulse_count", 32'(pcnt[2] - p2), 32'd0);
        check("glitch_level_seen", 32'(lvl_seen[2]), 32'd0);

        // Release bounce on channel 3.
        bus.btn_raw[3] = 1'b1; e = cyc + 1;
        at_edge(e + 8);
        check("relbounce_held", 32'(bus.btn_level[3]), 32'h1);
        p3 = pcnt[3]; lvl_dropped[3] = 0;
        bus.btn_raw[3] = 1'b0;
        at_edge(cyc + 2);
        bus.btn_raw[3] = 1'b1;
        at_edge(cyc + 15);
        check("relbounce_dropped", 32'(lvl_dropped[3]), 32'd0);
        check("relbounce_pulse_count", 32'(pcnt[3] - p3), 32'd0);
        bus.btn_raw[3] = 1'b0;
        at_edge(cyc + 10);

        // Hold-to-repeat on channel 0.
        bus.repeat_en = 1'b1;
        plog.delete(); logq = 1;
        p0 = pcnt[0];
        bus.btn_raw[0] = 1'b1; e = cyc + 1; a = e + 6;
        at_edge(a + 30);
        bus.btn_raw[0] = 1'b0;
        at_edge(cyc + 10);
        logq = 0;
        check("repeat_pulse_count", 32'(pcnt[0] - p0), 32'd9);
        check("repeat_accept", 32'(plog_at(0)), 32'(a));
        check("repeat_first", 32'(plog_at(1)), 32'(a + 10));
        check("repeat_second", 32'(plog_at(2)), 32'(a + 13));
        check("repeat_last", 32'(plog_at(8)), 32'(a + 31));

        // Same hold without repeat.
        bus.repeat_en = 1'b0;
        p0 = pcnt[0];
        bus.btn_raw[0] = 1'b1; e = cyc + 1;
        at_edge(e + 36);
        bus.btn_raw[0] = 1'b0;
        at_edge(cyc + 10);
        check("norepeat_pulse_count", 32'(pcnt[0] - p0), 32'd1);

        // All channels at once.
        bus.btn_raw = 4'hF; e = cyc + 1;
        at_edge(e + 5);
        check("simul_pulse_early", 32'(bus.btn_pulse), 32'h0);
        at_edge(e + 6);
        check("simul_pulse", 32'(bus.btn_pulse), 32'hF);
        check("simul_level", 32'(bus.btn_level), 32'hF);
        bus.btn_raw = 4'h0;
        at_edge(cyc + 10);

        // Reset while held: outputs clear before any clock edge; still-held buttons re-press.
        bus.btn_raw = 4'hF; e = cyc + 1;
        at_edge(e + 8);
        check("rst_held_level_before", 32'(bus.btn_level), 32'hF);
        #2 rst = 1'b1;
        #1;
        check("rst_held_level_now", 32'(bus.btn_level), 32'h0);
        check("rst_held_pulse_now", 32'(bus.btn_pulse), 32'h0);
        at_edge(cyc + 2);
        rst = 1'b0; e = cyc + 1;
        at_edge(e + 5);
        check("post_rst_pulse_early", 32'(bus.btn_pulse), 32'h0);
        at_edge(e + 6);
        check("post_rst_pulse", 32'(bus.btn_pulse), 32'hF);
        bus.btn_raw = 4'h0;
        at_edge(cyc + 10);

        // Reset during press check.
        bus.btn_raw = 4'hF; e = cyc + 1;
        at_edge(e + 3);
        #2 rst = 1'b1;
        #1;
        check("rst_chk_pulse_now", 32'(bus.btn_pulse), 32'h0);
        check("rst_chk_level_now", 32'(bus.btn_level), 32'h0);
        at_edge(cyc + 2);
        rst = 1'b0; e = cyc + 1;
        at_edge(e + 6);
        check("post_rst2_pulse", 32'(bus.btn_pulse), 32'hF);
        check("post_rst2_level", 32'(bus.btn_level), 32'hF);
        bus.btn_raw = 4'h0;
        at_edge(cyc + 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
